// File: rtl/branch_resolve_unit.sv
// -----------------------------------------------------------------------------
// branch_resolve_unit
//
// Resolves conditional branches and JALR jumps in the execute stage. For each
// request it works out the direction and the taken target, picks the correct
// next PC, and flags a mispredict against the fetch-stage prediction. Requests
// travel through a 1- or 2-stage valid/ready pipeline that can be flushed.
// Two wrapping counters track resolved requests and mispredicts.
//
// Parameters
//   DWIDTH  : width of operands, PC, immediate and target
//   LATENCY : pipeline stages from input handshake to output valid (1 or 2)
//   CWIDTH  : width of each performance counter
//
// Ports
//   clk, rst_n          : clock, synchronous active-low reset
//   flush               : kill every in-flight entry at the next edge
//   in_valid / in_ready : request handshake
//   rs1_in, rs2_in      : operands
//   func                : branch funct3 (ignored when is_jalr=1)
//   is_jalr             : unconditional JALR
//   pc_in, imm_in       : instruction PC and sign-extended offset
//   pred_taken/_target  : fetch-stage prediction
//   out_valid/out_ready : result handshake
//   taken, target       : resolved direction and taken target
//   redirect_pc         : correct next PC
//   mispredict          : prediction was wrong
//   br_count            : resolved requests (wraps)
//   misp_count          : mispredicted requests (wraps)
//   cnt_clr             : synchronous clear of both counters
// -----------------------------------------------------------------------------
module branch_resolve_unit #(
  parameter int DWIDTH  = 32,
  parameter int LATENCY = 1,
  parameter int CWIDTH  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DWIDTH-1:0] rs1_in,
  input  logic [DWIDTH-1:0] rs2_in,
  input  logic [2:0]        func,
  input  logic              is_jalr,
  input  logic [DWIDTH-1:0] pc_in,
  input  logic [DWIDTH-1:0] imm_in,
  input  logic              pred_taken,
  input  logic [DWIDTH-1:0] pred_target,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              taken,
  output logic [DWIDTH-1:0] target,
  output logic [DWIDTH-1:0] redirect_pc,
  output logic              mispredict,
  output logic [CWIDTH-1:0] br_count,
  output logic [CWIDTH-1:0] misp_count,
  input  logic              cnt_clr
);

  // A wrong direction is always a mispredict; a right "taken" guess still
  // mispredicts when it pointed somewhere else.
  function automatic logic calc_misp(input logic              tk,
                                     input logic [DWIDTH-1:0] tgt,
                                     input logic              ptk,
                                     input logic [DWIDTH-1:0] ptgt);
    return (tk != ptk) | (tk & ptk & (tgt != ptgt));
  endfunction

  logic              eq;
  logic              lt_s;
  logic              lt_u;
  logic              dir_taken;
  logic [DWIDTH-1:0] branch_sum;
  logic [DWIDTH-1:0] jalr_sum;
  logic [DWIDTH-1:0] tgt_sel;
  logic [DWIDTH-1:0] pc_plus4;
  logic              accept;
  logic              out_fire;

  // Front-end arithmetic shared by both pipeline depths: the comparisons,
  // the two candidate targets and the fall-through PC. All sums wrap.
  always_comb begin
    eq         = (rs1_in == rs2_in);
    lt_s       = ($signed(rs1_in) < $signed(rs2_in));
    lt_u       = (rs1_in < rs2_in);
    dir_taken  = 1'b0;
    if (is_jalr) begin
      dir_taken = 1'b1;
    end else begin
      case (func)
        3'b000:  dir_taken = eq;
        3'b001:  dir_taken = !eq;
        3'b100:  dir_taken = lt_s;
        3'b101:  dir_taken = !lt_s;
        3'b110:  dir_taken = lt_u;
        3'b111:  dir_taken = !lt_u;
        default: dir_taken = 1'b0;
      endcase
    end
    branch_sum  = pc_in + imm_in;
    jalr_sum    = rs1_in + imm_in;
    jalr_sum[0] = 1'b0;
    tgt_sel     = is_jalr ? jalr_sum : branch_sum;
    pc_plus4    = pc_in + DWIDTH'(4);
  end

  assign accept   = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;

  generate
    if (LATENCY == 1) begin : g_lat1

      // Single output register: it may load when empty or when the consumer
      // takes the current result on this same edge.
      assign in_ready = rst_n & !flush & (!out_valid | out_ready);

      // Output stage; everything is computed ahead of it.
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          out_valid   <= 1'b0;
          taken       <= 1'b0;
          target      <= '0;
          redirect_pc <= '0;
          mispredict  <= 1'b0;
        end else if (flush) begin
          out_valid <= 1'b0;
        end else if (accept) begin
          out_valid   <= 1'b1;
          taken       <= dir_taken;
          target      <= tgt_sel;
          redirect_pc <= dir_taken ? tgt_sel : pc_plus4;
          mispredict  <= calc_misp(dir_taken, tgt_sel, pred_taken, pred_target);
        end else if (out_fire) begin
          out_valid <= 1'b0;
        end
      end

    end else begin : g_lat2

      logic              s0_valid;
      logic              s0_taken;
      logic [DWIDTH-1:0] s0_target;
      logic [DWIDTH-1:0] s0_pc4;
      logic              s0_pred_taken;
      logic [DWIDTH-1:0] s0_pred_target;
      logic              s0_move;

      // Stage 0 hands its entry on whenever stage 1 is empty or draining, so
      // bubbles between the stages collapse.
      assign s0_move  = s0_valid & (!out_valid | out_ready);
      assign in_ready = rst_n & !flush & (!s0_valid | s0_move);

      // Stage 0 holds the resolved direction, the selected target sum, the
      // fall-through sum and the prediction it will be judged against.
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          s0_valid       <= 1'b0;
          s0_taken       <= 1'b0;
          s0_target      <= '0;
          s0_pc4         <= '0;
          s0_pred_taken  <= 1'b0;
          s0_pred_target <= '0;
        end else if (flush) begin
          s0_valid <= 1'b0;
        end else if (accept) begin
          s0_valid       <= 1'b1;
          s0_taken       <= dir_taken;
          s0_target      <= tgt_sel;
          s0_pc4         <= pc_plus4;
          s0_pred_taken  <= pred_taken;
          s0_pred_target <= pred_target;
        end else if (s0_move) begin
          s0_valid <= 1'b0;
        end
      end

      // Stage 1 picks the redirect PC and judges the prediction.
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          out_valid   <= 1'b0;
          taken       <= 1'b0;
          target      <= '0;
          redirect_pc <= '0;
          mispredict  <= 1'b0;
        end else if (flush) begin
          out_valid <= 1'b0;
        end else if (s0_move) begin
          out_valid   <= 1'b1;
          taken       <= s0_taken;
          target      <= s0_target;
          redirect_pc <= s0_taken ? s0_target : s0_pc4;
          mispredict  <= calc_misp(s0_taken, s0_target, s0_pred_taken, s0_pred_target);
        end else if (out_fire) begin
          out_valid <= 1'b0;
        end
      end

    end
  endgenerate

  // Performance counters. A result shown during a flush is discarded, so it
  // does not count; a clear wins over a same-cycle increment.
  always_ff @(posedge clk) begin
    if (!rst_n || cnt_clr) begin
      br_count   <= '0;
      misp_count <= '0;
    end else if (out_fire && !flush) begin
      br_count   <= br_count + CWIDTH'(1);
      misp_count <= misp_count + CWIDTH'(mispredict);
    end
  end

endmodule

// File: doc/branch_resolve_unit.md
# branch_resolve_unit

Pipelined branch/jump resolution unit for the RISC-V core's execute stage. It generalises the combinational branch comparator in several ways:
- parametrised data width and pipeline depth;
- valid/ready handshakes and flush support;
- computes target, redirect PC and mispredict against the fetch-stage prediction;
- keeps wrapping performance counters for resolved branches and mispredicts.

## Interface
- DWIDTH, 32, width of operands, PC, immediate and target
- LATENCY, 1, pipeline stages from input handshake to output valid; legal values 1 or 2
- CWIDTH, 32, width of each performance counter
- clk  input  1  clock, all state updates on rising edge
- rst_n  input  1  reset, synchronous, active-low
- flush  input  1  kill all in-flight entries this cycle
- in_valid  input  1  request valid
- in_ready  output  1  unit accepts request this cycle
- rs1_in, rs2_in  input  DWIDTH  operands
- func  input  3  RISC-V branch funct3: BEQ 000, BNE 001, BLT 100, BGE 101, BLTU 110, BGEU 111
- is_jalr  input  1  unconditional JALR; func ignored
- pc_in  input  DWIDTH  PC of the instruction
- imm_in  input  DWIDTH  sign-extended offset
- pred_taken  input  1  fetch prediction
- pred_target  input  DWIDTH  predicted target
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- taken  output  1  resolved direction
- target  output  DWIDTH  resolved taken target
- redirect_pc  output  DWIDTH  correct next PC
- mispredict  output  1  prediction wrong
- br_count  output  CWIDTH  resolved requests
- misp_count  output  CWIDTH  mispredicted requests
- cnt_clr  input  1  synchronous clear of both counters

## Operation
- Direction:
  - BEQ/BNE: equality of the operands.
  - BLT/BGE: signed less-than.
  - BLTU/BGEU: unsigned less-than.
  - funct3 010/011: taken=0.
  - is_jalr=1: taken=1.
- Target:
  - Branch: pc_in+imm_in.
  - JALR: (rs1_in+imm_in) with bit 0 forced to 0.
  - All sums are modulo 2^DWIDTH; wrap-around is not an error.
- redirect_pc = taken ? target : pc_in+4, also modulo 2^DWIDTH.
- mispredict = (taken != pred_taken) | (taken & pred_taken & target != pred_target).
- Pipeline stages:
  - Each stage holds one entry plus a valid bit.
  - A stage loads when it is empty or when its contents move on in the same cycle.
  - in_ready = !flush & (stage0 empty | stage0 advancing).
  - Bubbles collapse. There is no combinational path from out_ready to in_ready other than through stage occupancy logic.
- LATENCY=1: all computation happens before the single output register.
- LATENCY=2:
  - Stage 0 registers the compare result and both sums.
  - Stage 1 registers redirect_pc and mispredict.
- Output hold: out_valid=1 with out_ready=0 holds all outputs stable until accepted.
- Flush:
  - All stage valid bits clear at the next edge.
  - in_ready=0 during the flush cycle; no request is accepted.
  - A result presented at the output during the flush cycle is not counted, even if out_ready=1.
- Counters:
  - On the out_valid & out_ready & !flush handshake, br_count+=1 and misp_count+=mispredict.
  - Counters wrap at 2^CWIDTH.
  - cnt_clr has priority over increment: the count is 0 the next cycle even when a handshake occurs.

## Timing
- Reset (rst_n=0 at an edge):
  - All valid bits clear, out_valid=0.
  - br_count=0, misp_count=0.
  - taken, target, redirect_pc and mispredict read 0.
  - in_ready=0 while rst_n=0 and becomes 1 the cycle after release.
- Reset mid-operation discards in-flight entries; nothing is counted.
- Latency: a request accepted at edge N produces out_valid=1 after edge N+LATENCY-1 (LATENCY=1: visible in cycle N+1).
- Throughput: one request per cycle while out_ready=1.
- Full pipeline with out_ready=0: in_ready=0 and no entry is overwritten.
- Simultaneous output handshake and input acceptance: both take effect on the same edge; occupancy is unchanged.
- flush together with rst_n=0: reset behaviour applies.

## Test plan
- Direction: rs1=0xFFFFFFFF, rs2=0x00000001.
  - BLT -> taken=1; BLTU -> taken=0; BGE -> 0; BGEU -> 1.
  - BEQ with equal operands -> 1; funct3=010 -> 0.
- Target wrap: pc=0xFFFFFFFC, imm=8, BEQ taken.
  - target=0x00000004.
  - Same request with operands unequal -> redirect_pc=0x00000000.
- JALR: rs1=0x1001, imm=0x2.
  - target=0x1002, taken=1.
  - pred_taken=1, pred_target=0x1003 -> mispredict=1 and misp_count increments by 1.
- Back-pressure, LATENCY=2: stream 5 requests, hold out_ready=0 for 4 cycles.
  - in_ready drops after 2 accepted.
  - All 5 results emerge in order, unchanged.
  - br_count=5.
- Flush: flush asserted with 2 entries in flight and out_ready=1.
  - out_valid=0 the next cycle.
  - Counters unchanged.
  - The request offered during the flush cycle is not accepted.
- Counter clear and wrap: CWIDTH=4, 16 handshakes -> br_count=0.
  - cnt_clr in the same cycle as a mispredicting handshake -> both counters read 0.
